lru_tracker: RTL and testbench



---
 rtl/lru_pkg.sv | 18 +
 rtl/lru_tracker_if.sv | 34 +++
 rtl/lru_set_update.sv | 70 +++++++
 rtl/lru_tracker.sv | 119 +++++++++++
 tb/tb_lru_tracker.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/lru_pkg.sv
// Shared types for the true-LRU replacement tracker.
// Opcodes follow the request encoding seen on req_op.
package lru_pkg;

  typedef enum logic [2:0] {
    OP_TOUCH = 3'd0,
    OP_FILL  = 3'd1,
    OP_INVAL = 3'd2,
    OP_QUERY = 3'd3,
    OP_FLUSH = 3'd4
  } lru_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } lru_state_t;

endpackage

// File: rtl/lru_tracker_if.sv
// Request/response handshake bundle between cache controller
// and the LRU tracker.
interface lru_tracker_if #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [SET_W-1:0] req_set;
  logic [WAY_W-1:0] req_way;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WAY_W-1:0] rsp_way;
  logic             rsp_was_invalid;
  logic             err_touch_invalid;
  logic             busy;

  modport master (
    output req_valid, req_op, req_set, req_way, rsp_ready,
    input  req_ready, rsp_valid, rsp_way, rsp_was_invalid,
    input  err_touch_invalid, busy
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way, rsp_ready,
    output req_ready, rsp_valid, rsp_way, rsp_was_invalid,
    output err_touch_invalid, busy
  );

endinterface

// File: rtl/lru_set_update.sv
// Combinational next-state and victim select for one cache set.
// Ranks: 0 is MRU, NUM_WAYS-1 is LRU.
module lru_set_update
  import lru_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  lru_op_t                         op,
  input  logic [WAY_W-1:0]                way,
  input  logic [NUM_WAYS-1:0][WAY_W-1:0]  rank,
  input  logic [NUM_WAYS-1:0]             valid,
  output logic [NUM_WAYS-1:0][WAY_W-1:0]  next_rank,
  output logic [NUM_WAYS-1:0]             next_valid,
  output logic                            way_invalid,
  output logic [WAY_W-1:0]                victim,
  output logic                            victim_invalid
);

  logic [WAY_W-1:0] old;

  assign old         = rank[way];
  assign way_invalid = ~valid[way];

  always_comb begin
    next_rank  = rank;
    next_valid = valid;
    case (op)
      OP_TOUCH, OP_FILL: begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == way)
            next_rank[w] = '0;
          else if (rank[w] < old)
            next_rank[w] = rank[w] + WAY_W'(1);
        end
        if (op == OP_FILL)
          next_valid[way] = 1'b1;
      end
      OP_INVAL: begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == way)
            next_rank[w] = WAY_W'(NUM_WAYS - 1);
          else if (rank[w] > old)
            next_rank[w] = rank[w] - WAY_W'(1);
        end
        next_valid[way] = 1'b0;
      end
      default: ;
    endcase
  end

  // Invalid ways win over the LRU way; lowest index first.
  always_comb begin
    victim         = '0;
    victim_invalid = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim         = WAY_W'(w);
        victim_invalid = 1'b1;
      end
    end
    if (!victim_invalid) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (rank[w] == WAY_W'(NUM_WAYS - 1))
          victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/lru_tracker.sv
// True-LRU tracker: per-set ranks and valid bits in flops,
// touch/fill/inval updates, victim queries and a flush sweep.
module lru_tracker
  import lru_pkg::*;
#(
  parameter  int NUM_SETS = 16,
  parameter  int NUM_WAYS = 4,
  localparam int SET_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input logic        axis_aclk,
  input logic        axis_aresetn,
  lru_tracker_if.slave bus
);

  logic [NUM_WAYS-1:0][WAY_W-1:0] rank  [NUM_SETS];
  logic [NUM_WAYS-1:0]            valid [NUM_SETS];

  lru_state_t       state;
  logic [SET_W-1:0] flush_set;
  logic             rsp_valid;
  logic [WAY_W-1:0] rsp_way;
  logic             rsp_inv;
  logic             err;
  logic             busy;

  lru_op_t                        op;
  logic                           accept;
  logic [NUM_WAYS-1:0][WAY_W-1:0] next_rank;
  logic [NUM_WAYS-1:0]            next_valid;
  logic                           way_invalid;
  logic [WAY_W-1:0]               victim;
  logic                           victim_invalid;

  assign op = lru_op_t'(bus.req_op);

  assign bus.req_ready = axis_aresetn
                       & (state == ST_IDLE)
                       & ~(rsp_valid & ~bus.rsp_ready);

  assign accept = bus.req_valid & bus.req_ready;

  assign bus.rsp_valid         = rsp_valid;
  assign bus.rsp_way           = rsp_way;
  assign bus.rsp_was_invalid   = rsp_inv;
  assign bus.err_touch_invalid = err;
  assign bus.busy              = busy;

  lru_set_update #(
    .NUM_WAYS (NUM_WAYS)
  ) u_upd (
    .op             (op),
    .way            (bus.req_way),
    .rank           (rank[bus.req_set]),
    .valid          (valid[bus.req_set]),
    .next_rank      (next_rank),
    .next_valid     (next_valid),
    .way_invalid    (way_invalid),
    .victim         (victim),
    .victim_invalid (victim_invalid)
  );

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++)
          rank[s][w] <= WAY_W'(w);
        valid[s] <= '0;
      end
      state     <= ST_IDLE;
      flush_set <= '0;
      rsp_valid <= 1'b0;
      rsp_way   <= '0;
      rsp_inv   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Drain runs independently of the FSM, also during flush.
      if (rsp_valid && bus.rsp_ready)
        rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_TOUCH, OP_FILL, OP_INVAL: begin
                rank[bus.req_set]  <= next_rank;
                valid[bus.req_set] <= next_valid;
                if (op == OP_TOUCH && way_invalid)
                  err <= 1'b1;
              end
              OP_QUERY: begin
                rsp_valid <= 1'b1;
                rsp_way   <= victim;
                rsp_inv   <= victim_invalid;
              end
              OP_FLUSH: begin
                state     <= ST_FLUSH;
                busy      <= 1'b1;
                flush_set <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++)
            rank[flush_set][w] <= WAY_W'(w);
          valid[flush_set] <= '0;
          flush_set        <= flush_set + SET_W'(1);
          if (flush_set == SET_W'(NUM_SETS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lru_tracker.sv
// Directed bench for lru_tracker, 16 sets x 4 ways.
module tb_lru_tracker;
  import lru_pkg::*;

  localparam int NS = 16;
  localparam int NW = 4;
  localparam int SW = $clog2(NS);
  localparam int WW = $clog2(NW);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lru_tracker_if #(.NUM_SETS(NS), .NUM_WAYS(NW)) bus ();

  lru_tracker #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .bus          (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op,
                        input int set,
                        input int way);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = SW'(set);
    bus.req_way   = WW'(way);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_accept", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic query(input string tag, input int set,
                       input int ew, input int einv);
    do_req(OP_QUERY, set, 0);
    check({tag, "_vld"}, 32'(bus.rsp_valid), 1);
    check({tag, "_way"}, 32'(bus.rsp_way), 32'(ew));
    check({tag, "_inv"}, 32'(bus.rsp_was_invalid), 32'(einv));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad_rdy;
    int bad_rsp;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_set   = '0;
    bus.req_way   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rsp_vld", 32'(bus.rsp_valid), 0);
    check("rst_rsp_way", 32'(bus.rsp_way), 0);
    check("rst_rsp_inv", 32'(bus.rsp_was_invalid), 0);
    check("rst_err", 32'(bus.err_touch_invalid), 0);
    rst_n = 1'b1;

    query("q_empty", 0, 0, 1);

    // set 5 ranks after fills: [3,2,1,0]; after touch 0: [0,3,2,1]
    for (int w = 0; w < NW; w++) do_req(OP_FILL, 5, w);
    query("q_full", 5, 0, 0);
    do_req(OP_TOUCH, 5, 0);
    query("q_touch", 5, 1, 0);

    // inval 2: [0,2,3,1]; refill 2: [1,3,0,2]
    do_req(OP_INVAL, 5, 2);
    query("q_inval", 5, 2, 1);
    do_req(OP_FILL, 5, 2);
    query("q_refill", 5, 1, 0);
    check("err_clean", 32'(bus.err_touch_invalid), 0);

    for (int w = 0; w < NW; w++) do_req(OP_FILL, 3, w);
    query("q_set3", 3, 0, 0);

    do_req(OP_FLUSH, 0, 0);
    check("flush_busy_start", 32'(bus.busy), 1);
    n = 1;
    bad_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready) bad_rdy++;
      if (!bus.busy) break;
      if (i > 0) n++;
    end
    check("flush_cycles", 32'(n), NS);
    check("flush_ready_low", 32'(bad_rdy), 1);
    query("q_set3_flushed", 3, 0, 1);
    query("q_set5_flushed", 5, 0, 1);

    // set 1 full, touch 0 -> victim way 1
    for (int w = 0; w < NW; w++) do_req(OP_FILL, 1, w);
    do_req(OP_TOUCH, 1, 0);
    bus.rsp_ready = 1'b0;
    query("q_bp", 1, 1, 0);
    bad_rsp = 0;
    bad_rdy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_way !== WW'(1) ||
          bus.rsp_was_invalid !== 1'b0)
        bad_rsp++;
      if (bus.req_ready !== 1'b0) bad_rdy++;
    end
    check("bp_hold", 32'(bad_rsp), 0);
    check("bp_ready_low", 32'(bad_rdy), 0);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_QUERY;
    bus.req_set   = SW'(2);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("bp2_vld", 32'(bus.rsp_valid), 1);
    check("bp2_way", 32'(bus.rsp_way), 0);
    check("bp2_inv", 32'(bus.rsp_was_invalid), 1);

    do_req(3'd5, 4, 1);
    check("rsvd_no_rsp", 32'(bus.rsp_valid), 0);
    query("q_rsvd", 4, 0, 1);

    // set 9: touch 1 -> [1,0,2,3]; fill 0 -> [0,1,2,3], way 0 valid
    do_req(OP_TOUCH, 9, 1);
    check("err_set", 32'(bus.err_touch_invalid), 1);
    do_req(OP_FILL, 9, 0);
    query("q_set9", 9, 1, 1);
    check("err_sticky", 32'(bus.err_touch_invalid), 1);

    do_req(OP_FLUSH, 0, 0);
    repeat (3) @(negedge clk);
    check("mid_flush_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_err", 32'(bus.err_touch_invalid), 0);
    check("rst_mid_rsp", 32'(bus.rsp_valid), 0);
    check("rst_mid_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    query("q_after_rst", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
